// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding and wait-timer sizing.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_DONE   = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;
  localparam int unsigned WAIT_W             = 4;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait counter for an outstanding data-memory request: synchronous clear,
// count enable, and a terminal-count flag one increment before TERMINAL.
module wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = WAIT_W,
  parameter int unsigned TERMINAL = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the cycle whose missing ack would make the count reach TERMINAL.
  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one registered request per
// load/store, freezes the pipeline until ack, and traps halt/timeout.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_ALU_R,
  input  logic [31:0] MEM_RF_B,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_HALT,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] MEM_DOUT,
  output logic        dout_valid,
  output logic        halted,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dout_q, dout_d;
  logic        timer_clr, timer_en, timer_tc;
  logic        access;

  assign access = MEM_MemRead | MEM_MemWrite;

  wait_timer #(
    .WIDTH    (WAIT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .tc_o   (timer_tc)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (MEM_HALT) begin
          state_d = ST_HALTED;
        end else if (access) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          we_d      = MEM_MemWrite;
          addr_d    = MEM_ALU_R;
          wdata_d   = MEM_RF_B;
          timer_clr = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack is tested before the timeout so a last-cycle ack still completes.
        if (dm_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            dout_d = dm_rdata;
          end
        end else if (timer_tc) begin
          state_d = ST_ERR;
          req_d   = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  assign dm_req     = req_q;
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign MEM_DOUT   = dout_q;
  assign dout_valid = (state_q == ST_DONE);
  assign halted     = (state_q == ST_HALTED);
  assign bus_err    = (state_q == ST_ERR);
  assign stall      = ((state_q == ST_IDLE) & access & ~MEM_HALT)
                    | (state_q == ST_REQ) | (state_q == ST_ERR);

endmodule
